// File: rtl/bk_mpadd_seq.sv
// Multi-precision add/subtract sequencer that drives an external 16-bit adder
// one word per cycle, least significant first, with a registered inter-word carry.
module bk_mpadd_seq #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [16*WORDS-1:0] in_a,
  input  logic [16*WORDS-1:0] in_b,
  input  logic                in_cin,
  input  logic                in_sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [16*WORDS-1:0] out_sum,
  output logic                out_cout,
  output logic                out_ovf,
  output logic                busy,
  output logic [15:0]         add_a,
  output logic [15:0]         add_b,
  output logic                add_cin,
  input  logic [15:0]         add_s,
  input  logic                add_cout
);

  // state | meaning
  // IDLE  | ready for a request, adder inputs parked at zero
  // RUN   | word k on the adder, carry chained through c
  // DONE  | result held until out_ready

  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [KW-1:0] LASTK = KW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                   state;
  logic [KW-1:0]            k;
  logic                     c;
  logic [WORDS-1:0][15:0]   a_q;
  logic [WORDS-1:0][15:0]   b_q;
  logic [WORDS-1:0][15:0]   sum_q;

  assign in_ready = (state == IDLE);
  assign busy     = (state == RUN);
  assign out_sum  = sum_q;

  assign add_a   = (state == RUN) ? a_q[k] : 16'h0000;
  assign add_b   = (state == RUN) ? b_q[k] : 16'h0000;
  assign add_cin = (state == RUN) ? c : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      c         <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= in_a;
            // subtract as A + ~B + 1, with the borrow-in folded into the carry
            b_q   <= in_sub ? ~in_b : in_b;
            c     <= in_cin ^ in_sub;
            k     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_q[k] <= add_s;
          c        <= add_cout;
          if (k == LASTK) begin
            k         <= '0;
            out_cout  <= add_cout;
            out_ovf   <= (a_q[WORDS-1][15] == b_q[WORDS-1][15]) &&
                         (add_s[15] != a_q[WORDS-1][15]);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
